// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Owns the PC, issues instruction-memory reads
// and hands one instruction plus its NPC per cycle to the IF/ID latch.
// A one-entry skid buffer keeps data that returned while downstream was stalled.
// After a redirect or halt with a read still in flight, the DROP state waits
// for that read to complete and discards its data.
// Optional macro FETCH_PERF_EN adds the fetch_count / stall_cycles counters.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_in,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_out,
    output logic [31:0] NPC,
    output logic        instr_valid,
    output logic        fetch_halted,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DROP  = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc, skid_data, old_addr;
    logic        skid_valid, halt_pending;

    logic        in_fetch, req, avail, outstanding, deliver, hold;
    logic [31:0] addr, src, pc_plus4, redirect_tgt;

    // Request, availability and delivery decisions for the current cycle
    always_comb begin
        in_fetch     = (state == FETCH);
        req          = in_fetch ? !skid_valid : (state == DROP);
        addr         = (state == DROP) ? old_addr : pc;
        src          = skid_valid ? skid_data : imemload;
        pc_plus4     = pc + 32'd4;
        redirect_tgt = redirect_pc & ~32'h3;
        avail        = in_fetch & (skid_valid | (req & ihit));
        outstanding  = in_fetch & req & !ihit;
        deliver      = avail & !stall & !redirect_valid & !halt_in;
        hold         = avail &  stall & !redirect_valid & !halt_in;
    end

    // Outputs are forced to zero while reset is held, whatever the PC holds
    always_comb begin
        imemREN      = nRST & req;
        imemaddr     = {32{nRST}} & addr;
        instr_valid  = nRST & deliver;
        instr_out    = {32{nRST & deliver}} & src;
        NPC          = {32{nRST & deliver}} & pc_plus4;
        fetch_halted = nRST & (state == HALT);
    end

    // PC, skid buffer and FSM; halt beats redirect beats stall beats deliver
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= FETCH;
            pc           <= PC_INIT;
            skid_valid   <= 1'b0;
            skid_data    <= 32'h0;
            old_addr     <= 32'h0;
            halt_pending <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (halt_in) begin
                        skid_valid <= 1'b0;
                        if (outstanding) begin
                            halt_pending <= 1'b1;
                            old_addr     <= pc;
                            state        <= DROP;
                        end else begin
                            state <= HALT;
                        end
                    end else if (redirect_valid) begin
                        skid_valid <= 1'b0;
                        pc         <= redirect_tgt;
                        if (outstanding) begin
                            old_addr <= pc;
                            state    <= DROP;
                        end
                    end else if (deliver) begin
                        pc         <= pc_plus4;
                        skid_valid <= 1'b0;
                    end else if (hold && !skid_valid) begin
                        skid_valid <= 1'b1;
                        skid_data  <= imemload;
                    end
                end
                DROP: begin
                    if (redirect_valid && !halt_in)
                        pc <= redirect_tgt;
                    if (halt_in)
                        halt_pending <= 1'b1;
                    if (ihit)
                        state <= (halt_pending | halt_in) ? HALT : FETCH;
                end
                default: ;  // HALT: frozen until reset
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Delivered-instruction and stalled-with-data cycle counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (hold)    stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign stall_cycles = stall_cnt_q;
`else
    assign fetch_count  = 32'h0;
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven per-cycle vectors for fetch_stage, followed by
// hand-written sequences for reset mid-DROP, PC wrap and halt with a read in flight.
module tb_fetch_stage;

    logic        CLK, nRST, ihit, stall, redirect_valid, halt_in;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, instr_valid, fetch_halted;
    logic [31:0] imemaddr, instr_out, NPC, fetch_count, stall_cycles;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.PC_INIT(32'h0)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_in(halt_in),
        .imemREN(imemREN), .imemaddr(imemaddr), .instr_out(instr_out), .NPC(NPC),
        .instr_valid(instr_valid), .fetch_halted(fetch_halted),
        .fetch_count(fetch_count), .stall_cycles(stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        halt;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        halted;
        logic [31:0] fc;
        logic [31:0] sc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic hi, logic [31:0] ld, logic st, logic rv, logic [31:0] rpc,
                                logic ht, logic ren, logic [31:0] ad, logic [31:0] in,
                                logic [31:0] np, logic vl, logic hd, logic [31:0] fc, logic [31:0] sc);
        vec_t v;
        v.ihit = hi; v.load = ld; v.stall = st; v.rv = rv; v.rpc = rpc; v.halt = ht;
        v.ren = ren; v.addr = ad; v.instr = in; v.npc = np; v.valid = vl; v.halted = hd;
        v.fc = fc; v.sc = sc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ren, input logic [31:0] ad,
                           input logic [31:0] in, input logic [31:0] np,
                           input logic vl, input logic hd);
        chk({tag, ".imemREN"},      {31'h0, imemREN},      {31'h0, ren});
        chk({tag, ".imemaddr"},     imemaddr,              ad);
        chk({tag, ".instr_out"},    instr_out,             in);
        chk({tag, ".NPC"},          NPC,                   np);
        chk({tag, ".instr_valid"},  {31'h0, instr_valid},  {31'h0, vl});
        chk({tag, ".fetch_halted"}, {31'h0, fetch_halted}, {31'h0, hd});
    endtask

    task automatic drive(input logic hi, input logic [31:0] ld, input logic st,
                         input logic rv, input logic [31:0] rpc, input logic ht);
        ihit = hi; imemload = ld; stall = st; redirect_valid = rv; redirect_pc = rpc; halt_in = ht;
    endtask

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Test 1: straight-line fetch 0,4
        tbl.push_back(mk(1, 32'hA5A5_0000, 0, 0, 0, 0, 1, 32'h00, 32'hA5A5_0000, 32'h04, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'hA5A5_0004, 0, 0, 0, 0, 1, 32'h04, 32'hA5A5_0004, 32'h08, 1, 0, 1, 0));
        // Test 2: data at pc=8 arrives under stall, held in skid for 3 cycles
        tbl.push_back(mk(1, 32'hA5A5_0008, 1, 0, 0, 0, 1, 32'h08, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 32'h1111_1111, 1, 0, 0, 0, 0, 32'h08, 0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 32'h2222_2222, 1, 0, 0, 0, 0, 32'h08, 0, 0, 0, 0, 2, 2));
        tbl.push_back(mk(0, 32'h3333_3333, 0, 0, 0, 0, 0, 32'h08, 32'hA5A5_0008, 32'h0C, 1, 0, 2, 3));
        tbl.push_back(mk(1, 32'hA5A5_000C, 0, 0, 0, 0, 1, 32'h0C, 32'hA5A5_000C, 32'h10, 1, 0, 3, 3));
        // Test 3: redirect with ihit at 0x10; target low bits dropped
        tbl.push_back(mk(1, 32'hA5A5_0010, 0, 1, 32'h103, 0, 1, 32'h10, 0, 0, 0, 0, 4, 3));
        tbl.push_back(mk(1, 32'hA5A5_0100, 0, 0, 0, 0, 1, 32'h100, 32'hA5A5_0100, 32'h104, 1, 0, 4, 3));
        // Test 4: get to 0x20, then redirect with the read outstanding -> DROP
        tbl.push_back(mk(1, 32'hA5A5_0104, 0, 1, 32'h20, 0, 1, 32'h104, 0, 0, 0, 0, 5, 3));
        tbl.push_back(mk(0, 32'h0, 0, 1, 32'h40, 0, 1, 32'h20, 0, 0, 0, 0, 5, 3));
        tbl.push_back(mk(0, 32'h0, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0, 5, 3));
        tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0, 5, 3));
        tbl.push_back(mk(1, 32'hA5A5_0040, 0, 0, 0, 0, 1, 32'h40, 32'hA5A5_0040, 32'h44, 1, 0, 5, 3));
        // Test 5: halt with redirect and ihit -> HALT, inputs ignored afterwards
        tbl.push_back(mk(1, 32'hA5A5_0044, 0, 1, 32'h80, 1, 1, 32'h44, 0, 0, 0, 0, 6, 3));
        tbl.push_back(mk(1, 32'h5555_5555, 0, 1, 32'h200, 0, 0, 32'h44, 0, 0, 0, 1, 6, 3));
        tbl.push_back(mk(0, 32'h6666_6666, 1, 0, 0, 0, 0, 32'h44, 0, 0, 0, 1, 6, 3));
        tbl.push_back(mk(1, 32'h7777_7777, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0, 1, 6, 3));

        // Reset state: everything zero while nRST is low
        #2;
        chk_out("reset", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("reset.fetch_count", fetch_count, 32'h0);
        chk("reset.stall_cycles", stall_cycles, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (tbl[i]) begin
            @(negedge CLK);
            drive(tbl[i].ihit, tbl[i].load, tbl[i].stall, tbl[i].rv, tbl[i].rpc, tbl[i].halt);
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].ren, tbl[i].addr, tbl[i].instr,
                    tbl[i].npc, tbl[i].valid, tbl[i].halted);
            chk($sformatf("vec%0d.fetch_count", i), fetch_count, perf(tbl[i].fc));
            chk($sformatf("vec%0d.stall_cycles", i), stall_cycles, perf(tbl[i].sc));
        end

        // HALT persists for 10 more cycles with redirect/ihit activity
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            drive(1'b1, 32'h9999_0000 + k, 1'b0, k[0], 32'h300, 1'b0);
            #1;
            chk_out($sformatf("halt%0d", k), 0, 32'h44, 32'h0, 32'h0, 0, 1);
        end
        chk("halt.fetch_count", fetch_count, perf(32'd6));

        // Test 6: reset, enter DROP, then reset asynchronously mid-DROP
        @(negedge CLK);
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
        #1;
        chk_out("drop_enter", 1, 32'h0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_out("drop_wait", 1, 32'h0, 32'h0, 32'h0, 0, 0);
        #1;
        nRST = 1'b0;
        #1;
        chk_out("async_rst", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_out("post_rst", 1, 32'h0, 32'h0000_1234, 32'h4, 1, 0);
        chk("post_rst.stall_cycles", stall_cycles, 32'h0);

        // PC wrap: redirect to top word (low bits forced), deliver, NPC wraps to 0
        @(negedge CLK);
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        #1;
        chk_out("wrap_redir", 1, 32'h4, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);
        drive(1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_out("wrap_top", 1, 32'hFFFF_FFFC, 32'h0000_0055, 32'h0, 1, 0);

        // Halt with a read in flight: DROP at the old address, then HALT on ihit
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk_out("halt_pend", 1, 32'h0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);
        drive(1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_out("halt_drop", 1, 32'h0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);
        drive(1'b1, 32'h0000_0088, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_out("halt_done", 0, 32'h0, 32'h0, 32'h0, 0, 1);
        chk("halt_done.fetch_count", fetch_count, perf(32'd2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
